// File: rtl/serial_borrow_down_counter_pkg.sv
// Shared types for the serial-borrow down counter: FSM state encoding.
package serial_borrow_down_counter_pkg;

    localparam int unsigned STATE_W = 2;

    // Encodings are shared with the serial-carry up-counter family
    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/serial_borrow_down_counter_sbd_cell.sv
// One stage of the borrow chain: toggle flop with synchronous load and borrow-out.
module serial_borrow_down_counter_sbd_cell (
    input  logic clock,
    input  logic reset_,
    input  logic ld,
    input  logic d,
    input  logic bin,
    output logic q,
    output logic bout
);

    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (bin) begin
            q <= ~q;
        end
    end

    // Borrow ripples on only through bits that are already zero
    assign bout = bin & ~q;

endmodule

// File: rtl/serial_borrow_down_counter.sv
// Loadable down counter with serial borrow chain, one-shot/auto-reload FSM and expiry tally.
module serial_borrow_down_counter
    import serial_borrow_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned EVW   = 8
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             T,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             bout,
    output logic             done,
    output logic [EVW-1:0]   EXP_CNT
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload;
    logic [WIDTH:0]   borrow;
    logic             cell_ld;
    logic [WIDTH-1:0] cell_d;
    logic             expire;

    assign borrow[0] = T & (state == S_RUN);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        serial_borrow_down_counter_sbd_cell u_cell (
            .clock  (clock),
            .reset_ (reset_),
            .ld     (cell_ld),
            .d      (cell_d[i]),
            .bin    (borrow[i]),
            .q      (Q[i]),
            .bout   (borrow[i+1])
        );
    end

    assign bout = borrow[WIDTH];

    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Terminal borrow overrides the chain with a parallel load so Q never wraps past zero
    always_comb begin
        state_next = state;
        cell_ld    = 1'b0;
        cell_d     = D;
        expire     = 1'b0;
        if (load) begin
            cell_ld    = 1'b1;
            cell_d     = D;
            state_next = S_RUN;
        end else if (bout) begin
            expire  = 1'b1;
            cell_ld = 1'b1;
            if (auto_reload) begin
                cell_d = reload;
            end else begin
                cell_d     = '0;
                state_next = S_EXPIRED;
            end
        end
    end

    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            reload  <= '0;
            done    <= 1'b0;
            EXP_CNT <= '0;
        end else begin
            if (load) begin
                reload <= D;
            end
            done <= (state_next == S_EXPIRED);
            if (expire && (EXP_CNT != '1)) begin
                EXP_CNT <= EXP_CNT + EVW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_borrow_down_counter.sv
// Directed bench for serial_borrow_down_counter, including a two-stage cascade.
module tb_serial_borrow_down_counter;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned EVW   = 8;

    logic             clock;
    logic             reset_;
    logic             load;
    logic [WIDTH-1:0] D;
    logic             T;
    logic             auto_reload;
    logic [WIDTH-1:0] Q;
    logic             bout;
    logic             done;
    logic [EVW-1:0]   EXP_CNT;

    logic             c_load;
    logic [7:0]       c_d;
    logic             c_t;
    logic             c_ar;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             lo_bout;
    logic             hi_bout;
    logic             lo_done;
    logic             hi_done;
    logic [EVW-1:0]   lo_exp;
    logic [EVW-1:0]   hi_exp;

    int vectors = 0;
    int errors  = 0;

    serial_borrow_down_counter #(.WIDTH(WIDTH), .EVW(EVW)) dut (
        .clock       (clock),
        .reset_      (reset_),
        .load        (load),
        .D           (D),
        .T           (T),
        .auto_reload (auto_reload),
        .Q           (Q),
        .bout        (bout),
        .done        (done),
        .EXP_CNT     (EXP_CNT)
    );

    serial_borrow_down_counter #(.WIDTH(WIDTH), .EVW(EVW)) u_lo (
        .clock       (clock),
        .reset_      (reset_),
        .load        (c_load),
        .D           (c_d[3:0]),
        .T           (c_t),
        .auto_reload (c_ar),
        .Q           (lo_q),
        .bout        (lo_bout),
        .done        (lo_done),
        .EXP_CNT     (lo_exp)
    );

    serial_borrow_down_counter #(.WIDTH(WIDTH), .EVW(EVW)) u_hi (
        .clock       (clock),
        .reset_      (reset_),
        .load        (c_load),
        .D           (c_d[7:4]),
        .T           (lo_bout),
        .auto_reload (c_ar),
        .Q           (hi_q),
        .bout        (hi_bout),
        .done        (hi_done),
        .EXP_CNT     (hi_exp)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next falling (active) edge and settle
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        int pulses;
        reset_ = 1'b0; load = 1'b0; D = '0; T = 1'b0; auto_reload = 1'b0;
        c_load = 1'b0; c_d = '0; c_t = 1'b0; c_ar = 1'b0;

        step();
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_exp", 32'(EXP_CNT), 32'd0);
        reset_ = 1'b1;
        T = 1'b1;
        #1 chk("idle_bout", 32'(bout), 32'd0);
        step();
        chk("idle_hold", 32'(Q), 32'd0);

        // Reset mid-count
        load = 1'b1; D = 4'd5; T = 1'b0;
        step();
        load = 1'b0;
        chk("t1_load", 32'(Q), 32'd5);
        T = 1'b1;
        step();
        chk("t1_dec", 32'(Q), 32'd4);
        #2 reset_ = 1'b0;
        #1;
        chk("t1_async_q", 32'(Q), 32'd0);
        chk("t1_async_done", 32'(done), 32'd0);
        chk("t1_async_exp", 32'(EXP_CNT), 32'd0);
        reset_ = 1'b1;
        #1 chk("t1_idle_bout", 32'(bout), 32'd0);
        step();
        chk("t1_idle_q", 32'(Q), 32'd0);

        // One-shot from 3
        load = 1'b1; D = 4'd3; auto_reload = 1'b0; T = 1'b0;
        step();
        load = 1'b0;
        T = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_q", 32'(Q), 32'(3 - k));
            chk("t2_bout", 32'(bout), (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_exp", 32'(EXP_CNT), 32'd1);
        chk("t2_q0", 32'(Q), 32'd0);
        chk("t2_exp_bout", 32'(bout), 32'd0);
        step();
        chk("t2_hold_q", 32'(Q), 32'd0);
        chk("t2_hold_exp", 32'(EXP_CNT), 32'd1);

        // Auto-reload from 2, period 3
        load = 1'b1; D = 4'd2; auto_reload = 1'b1;
        step();
        load = 1'b0;
        chk("t3_done_clr", 32'(done), 32'd0);
        for (int k = 0; k < 9; k++) begin
            chk("t3_q", 32'(Q), 32'(2 - (k % 3)));
            chk("t3_bout", 32'(bout), (k % 3 == 2) ? 32'd1 : 32'd0);
            step();
        end
        chk("t3_exp", 32'(EXP_CNT), 32'd4);
        chk("t3_q_end", 32'(Q), 32'd2);

        // Gated T at Q=4
        load = 1'b1; D = 4'd4; T = 1'b0;
        step();
        load = 1'b0;
        T = 1'b1; #1 chk("t4_bout", 32'(bout), 32'd0); step(); chk("t4_q", 32'(Q), 32'd3);
        T = 1'b0; #1 chk("t4_bout", 32'(bout), 32'd0); step(); chk("t4_q", 32'(Q), 32'd3);
        T = 1'b1; #1 chk("t4_bout", 32'(bout), 32'd0); step(); chk("t4_q", 32'(Q), 32'd2);
        T = 1'b0; #1 chk("t4_bout", 32'(bout), 32'd0); step(); chk("t4_q", 32'(Q), 32'd2);

        // Load wins over expiry at Q=0
        load = 1'b1; D = 4'd1;
        step();
        load = 1'b0; T = 1'b1;
        step();
        chk("t5_q0", 32'(Q), 32'd0);
        load = 1'b1; D = 4'd6;
        step();
        load = 1'b0;
        chk("t5_load_q", 32'(Q), 32'd6);
        chk("t5_load_exp", 32'(EXP_CNT), 32'd4);

        // Divide-by-1 and saturation
        load = 1'b1; D = 4'd0;
        step();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t5_div1_bout", 32'(bout), 32'd1);
            step();
            chk("t5_div1_q", 32'(Q), 32'd0);
        end
        chk("t5_div1_exp", 32'(EXP_CNT), 32'd7);
        repeat (260) step();
        chk("t6_sat", 32'(EXP_CNT), 32'd255);
        chk("t6_sat_bout", 32'(bout), 32'd1);
        T = 1'b0;

        // Cascade: low stage reload must be F for binary behaviour, so preload F and pre-count to 2
        c_ar = 1'b1; c_load = 1'b1; c_d = 8'h1F;
        step();
        c_load = 1'b0; c_t = 1'b1;
        repeat (13) step();
        chk("t6_cas_start", 32'({hi_q, lo_q}), 32'h12);
        pulses = 0;
        for (int k = 0; k < 19; k++) begin
            chk("t6_cas_val", 32'({hi_q, lo_q}), 32'(18 - k));
            chk("t6_cas_hbout", 32'(hi_bout), (k == 18) ? 32'd1 : 32'd0);
            if (hi_bout) pulses++;
            step();
        end
        chk("t6_cas_pulses", 32'(pulses), 32'd1);
        chk("t6_cas_hexp", 32'(hi_exp), 32'd1);
        chk("t6_cas_reload", 32'({hi_q, lo_q}), 32'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
